// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares the single-port framebuffer RAM between display
// reads (absolute priority, fixed latency) and round-robin CPU/gfx writers.
module framebuffer_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_cpu_wr_valid,
    output logic              o_cpu_wr_ready,
    input  logic [ADDR_W-1:0] i_cpu_wr_addr,
    input  logic [DATA_W-1:0] i_cpu_wr_data,
    input  logic              i_gfx_wr_valid,
    output logic              o_gfx_wr_ready,
    input  logic [ADDR_W-1:0] i_gfx_wr_addr,
    input  logic [DATA_W-1:0] i_gfx_wr_data,
    input  logic              i_gfx_wr_last,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BURST);
    localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BC_W-1:0] r_burst_cnt;
    logic [BC_W-1:0] w_burst_cnt_nxt;
    logic [BC_W-1:0] w_burst_inc;
    logic            r_ptr_gfx;
    logic            w_ptr_gfx_nxt;
    logic            w_gnt_cpu;
    logic            w_gnt_gfx;
    logic            w_gnt_wr;
    logic            w_conflict;
    logic            r_rd_v1;
    logic            r_rd_v2;

    assign w_gnt_wr       = w_gnt_cpu | w_gnt_gfx;
    assign w_burst_inc    = r_burst_cnt + BC_ONE;
    assign w_conflict     = i_disp_req & (i_cpu_wr_valid | i_gfx_wr_valid);
    assign o_cpu_wr_ready = w_gnt_cpu;
    assign o_gfx_wr_ready = w_gnt_gfx;

    // Grant: display first, then locked gfx burst, then round-robin writers.
    always_comb begin
        w_gnt_cpu = 1'b0;
        w_gnt_gfx = 1'b0;
        if (rst_n && !i_disp_req) begin
            if (r_state == S_LOCK) begin
                w_gnt_gfx = i_gfx_wr_valid;
            end else if (i_cpu_wr_valid && i_gfx_wr_valid) begin
                w_gnt_cpu = r_ptr_gfx;
                w_gnt_gfx = !r_ptr_gfx;
            end else begin
                w_gnt_cpu = i_cpu_wr_valid;
                w_gnt_gfx = i_gfx_wr_valid;
            end
        end
    end

    // Next state of the burst lock, burst counter and round-robin pointer.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_ptr_gfx_nxt   = r_ptr_gfx;
        if (w_gnt_cpu) begin
            w_ptr_gfx_nxt = 1'b0;
        end
        if (w_gnt_gfx) begin
            w_ptr_gfx_nxt = 1'b1;
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_gfx && !i_gfx_wr_last && (MAX_BURST > 1)) begin
                    w_state_nxt     = S_LOCK;
                    w_burst_cnt_nxt = BC_ONE;
                end
            end
            S_LOCK: begin
                if (w_gnt_gfx) begin
                    w_burst_cnt_nxt = w_burst_inc;
                    if (i_gfx_wr_last || (w_burst_inc == BC_MAX)) begin
                        w_state_nxt     = S_IDLE;
                        w_burst_cnt_nxt = '0;
                    end
                end else if (!i_disp_req && !i_gfx_wr_valid) begin
                    w_state_nxt     = S_IDLE;
                    w_burst_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Lock state, burst counter and pointer registers; CPU wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_ptr_gfx   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_ptr_gfx   <= w_ptr_gfx_nxt;
        end
    end

    // Registered RAM port; address and data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ram_en    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
        end else begin
            o_ram_en <= i_disp_req | w_gnt_wr;
            o_ram_we <= w_gnt_wr;
            if (i_disp_req) begin
                o_ram_addr <= i_disp_addr;
            end else if (w_gnt_cpu) begin
                o_ram_addr  <= i_cpu_wr_addr;
                o_ram_wdata <= i_cpu_wr_data;
            end else if (w_gnt_gfx) begin
                o_ram_addr  <= i_gfx_wr_addr;
                o_ram_wdata <= i_gfx_wr_data;
            end
        end
    end

    // Read pipeline: request, RAM enable, RAM data, registered display data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v1      <= 1'b0;
            r_rd_v2      <= 1'b0;
            o_disp_valid <= 1'b0;
            o_disp_data  <= '0;
        end else begin
            r_rd_v1      <= i_disp_req;
            r_rd_v2      <= r_rd_v1;
            o_disp_valid <= r_rd_v2;
            if (r_rd_v2) begin
                o_disp_data <= i_ram_rdata;
            end
        end
    end

    // Saturating count of cycles a writer was held off by the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_conflict_cnt <= '0;
        end else if (w_conflict && (o_conflict_cnt != {CNT_W{1'b1}})) begin
            o_conflict_cnt <= o_conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed stimulus against a transaction-level
// model of the arbiter, plus literal grant/read sequences per scenario.
module tb_framebuffer_arbiter;

    localparam int AW = 20;
    localparam int DW = 1;
    localparam int MB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          cpu_wr_valid = 1'b0;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          gfx_wr_valid = 1'b0;
    logic          gfx_wr_ready;
    logic [AW-1:0] gfx_wr_addr = '0;
    logic [DW-1:0] gfx_wr_data = '0;
    logic          gfx_wr_last = 1'b0;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [CW-1:0] conflict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    framebuffer_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_valid(disp_valid), .o_disp_data(disp_data),
        .i_cpu_wr_valid(cpu_wr_valid), .o_cpu_wr_ready(cpu_wr_ready),
        .i_cpu_wr_addr(cpu_wr_addr), .i_cpu_wr_data(cpu_wr_data),
        .i_gfx_wr_valid(gfx_wr_valid), .o_gfx_wr_ready(gfx_wr_ready),
        .i_gfx_wr_addr(gfx_wr_addr), .i_gfx_wr_data(gfx_wr_data),
        .i_gfx_wr_last(gfx_wr_last),
        .o_ram_en(ram_en), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string nm, input string act,
                         input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    // Synchronous single-port RAM, initial content mem[a] = a[0].
    logic [DW-1:0] ram_mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = DW'(i % 2);
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[9:0]] <= ram_wdata;
            else ram_rdata <= ram_mem[ram_addr[9:0]];
        end
    end

    // Transaction-level model: who may write, what the RAM holds,
    // which reads are due on which cycle.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    rd_t           rq[$];
    rd_t           rt;
    logic [DW-1:0] m_mem [0:1023];
    int            cyc;
    int            m_beats;
    logic          m_last_gfx;
    int            m_conf;
    logic          m_ram_en, m_ram_we;
    logic [AW-1:0] m_ram_addr;
    logic [DW-1:0] m_ram_wdata, m_disp_data;
    logic          e_cpu, e_gfx, e_dv;

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = DW'(i % 2);
    end

    always @(negedge clk) begin
        e_cpu = 1'b0;
        e_gfx = 1'b0;
        e_dv  = 1'b0;
        if (!rst_n) begin
            rq.delete();
            cyc = 0; m_beats = 0; m_last_gfx = 1'b1; m_conf = 0;
            m_ram_en = 0; m_ram_we = 0; m_ram_addr = '0;
            m_ram_wdata = '0; m_disp_data = '0;
        end else begin
            if (disp_req) begin
                e_cpu = 1'b0;
            end else if (m_beats > 0) begin
                e_gfx = gfx_wr_valid;
            end else if (cpu_wr_valid && gfx_wr_valid) begin
                e_cpu = m_last_gfx;
                e_gfx = !m_last_gfx;
            end else begin
                e_cpu = cpu_wr_valid;
                e_gfx = gfx_wr_valid;
            end
            if (rq.size() > 0) begin
                if (rq[0].due == cyc) begin
                    e_dv = 1'b1;
                    rt = rq.pop_front();
                    m_disp_data = rt.d;
                end
            end
        end
        chk("cpu_ready", 32'(cpu_wr_ready), 32'(e_cpu));
        chk("gfx_ready", 32'(gfx_wr_ready), 32'(e_gfx));
        chk("ram_en", 32'(ram_en), 32'(m_ram_en));
        chk("ram_we", 32'(ram_we), 32'(m_ram_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_ram_wdata));
        chk("disp_valid", 32'(disp_valid), 32'(e_dv));
        chk("disp_data", 32'(disp_data), 32'(m_disp_data));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        if (rst_n) begin
            if (disp_req && (cpu_wr_valid || gfx_wr_valid)
                && m_conf < (1 << CW) - 1) m_conf++;
            if (disp_req) begin
                m_ram_en = 1; m_ram_we = 0; m_ram_addr = disp_addr;
                rt.due = cyc + 3;
                rt.d = m_mem[disp_addr[9:0]];
                rq.push_back(rt);
            end else if (e_cpu) begin
                m_ram_en = 1; m_ram_we = 1;
                m_ram_addr = cpu_wr_addr; m_ram_wdata = cpu_wr_data;
                m_mem[cpu_wr_addr[9:0]] = cpu_wr_data;
                m_last_gfx = 1'b0;
            end else if (e_gfx) begin
                m_ram_en = 1; m_ram_we = 1;
                m_ram_addr = gfx_wr_addr; m_ram_wdata = gfx_wr_data;
                m_mem[gfx_wr_addr[9:0]] = gfx_wr_data;
                m_last_gfx = 1'b1;
                if (m_beats == 0) begin
                    m_beats = (gfx_wr_last || MB == 1) ? 0 : 1;
                end else begin
                    m_beats++;
                    if (gfx_wr_last || m_beats == MB) m_beats = 0;
                end
            end else begin
                m_ram_en = 0; m_ram_we = 0;
            end
            if (!disp_req && !gfx_wr_valid) m_beats = 0;
            cyc++;
        end
    end

    task automatic idle_inputs();
        disp_req = 0; cpu_wr_valid = 0; gfx_wr_valid = 0; gfx_wr_last = 0;
    endtask

    // Drives ncyc cycles; seq logs grants (C/G/D/-), dseq logs display data.
    task automatic run(input int ncyc, input int cpu_n, input int cpu_dly,
                       input int gfx_n, input int glen,
                       input logic [31:0] dmask, input int dbase,
                       output string seq, output string dseq);
        int    cd = 0;
        int    gd = 0;
        string ch;
        seq = "";
        dseq = "";
        for (int c = 0; c < ncyc; c++) begin
            disp_req     = dmask[c];
            disp_addr    = AW'(dbase + c);
            cpu_wr_valid = (c >= cpu_dly) && (cd < cpu_n);
            cpu_wr_addr  = AW'(32'h100 + cd);
            cpu_wr_data  = cd[0] ? 1'b1 : 1'b0;
            gfx_wr_valid = gd < gfx_n;
            gfx_wr_addr  = AW'(32'h200 + gd);
            gfx_wr_data  = gd[0] ? 1'b0 : 1'b1;
            gfx_wr_last  = (gd % glen) == glen - 1;
            #1;
            if (cpu_wr_ready && gfx_wr_ready) ch = "X";
            else if (cpu_wr_ready) ch = "C";
            else if (gfx_wr_ready) ch = "G";
            else if (disp_req) ch = "D";
            else ch = "-";
            seq = {seq, ch};
            if (!disp_valid) ch = "-";
            else if (disp_data[0]) ch = "1";
            else ch = "0";
            dseq = {dseq, ch};
            if (cpu_wr_valid && cpu_wr_ready) cd++;
            if (gfx_wr_valid && gfx_wr_ready) gd++;
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    string s, ds;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_cpu_ready", 32'(cpu_wr_ready), 0);
        rst_n = 1'b1;

        run(12, 0, 0, 0, 1, 32'hFF, 0, s, ds);
        chk_s("disp_only_grants", s, "DDDDDDDD----");
        chk_s("disp_only_data", ds, "---01010101-");

        run(8, 4, 0, 4, 1, 32'h0, 0, s, ds);
        chk_s("rr_alternate", s, "CGCGCGCG");
        chk_s("rr_no_disp", ds, "--------");

        run(5, 1, 1, 3, 3, 32'h0, 0, s, ds);
        chk_s("burst3_last", s, "GGGC-");

        run(8, 1, 1, 6, 6, 32'h0, 0, s, ds);
        chk_s("burst6_cap4", s, "GGGGCGG-");

        run(10, 1, 1, 6, 6, 32'hC, 32'h1FE, s, ds);
        chk_s("burst_preempt", s, "GGDDGGCGG-");
        chk_s("preempt_data", ds, "-----10---");
        chk("conflict_two", 32'(conflict_cnt), 2);

        run(4, 1, 2, 2, 6, 32'h0, 0, s, ds);
        chk_s("burst_abandon", s, "GG-C");

        disp_req = 1; disp_addr = AW'(1); cpu_wr_valid = 1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            if (i == 99) chk("conflict_102", 32'(conflict_cnt), 102);
        end
        chk("conflict_sat", 32'(conflict_cnt), 32'hFFFF);
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;

        gfx_wr_valid = 1; gfx_wr_addr = AW'(32'h300); gfx_wr_data = 1;
        @(posedge clk);
        #1;
        disp_req = 1; disp_addr = AW'(2); gfx_wr_addr = AW'(32'h301);
        @(posedge clk);
        #1;
        disp_req = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ram_en", 32'(ram_en), 0);
        chk("async_ram_we", 32'(ram_we), 0);
        chk("async_ram_addr", 32'(ram_addr), 0);
        chk("async_ram_wdata", 32'(ram_wdata), 0);
        chk("async_disp_valid", 32'(disp_valid), 0);
        chk("async_disp_data", 32'(disp_data), 0);
        chk("async_conflict", 32'(conflict_cnt), 0);
        chk("async_gfx_ready", 32'(gfx_wr_ready), 0);
        chk("async_cpu_ready", 32'(cpu_wr_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(6, 1, 0, 1, 1, 32'h0, 0, s, ds);
        chk_s("post_reset_grants", s, "CG----");
        chk_s("post_reset_no_read", ds, "------");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
